// File: rtl/div24u_seq_pkg.sv
// Shared types and sizing for the div24u_seq restoring divider.
package div_pkg;

  localparam int unsigned DW_DEF = 12;
  localparam int unsigned CNT_W_DEF = $clog2(DW_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/div24u_seq_if.sv
// Operand/result handshake bundle for div24u_seq; rem exists only with DIV_REMAINDER_EN.
interface div24u_seq_if
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [2*DW-1:0]   dividend;
  logic [DW-1:0]     divisor;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     quot;
`ifdef DIV_REMAINDER_EN
  logic [DW-1:0]     rem;
`endif
  logic              ovf;
  logic              dz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
`ifdef DIV_REMAINDER_EN
    input  rem,
`endif
    input  in_ready, out_valid, quot, ovf, dz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
`ifdef DIV_REMAINDER_EN
    output rem,
`endif
    output in_ready, out_valid, quot, ovf, dz
  );

endinterface

// File: rtl/div24u_seq_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [DW-1:0] r,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] r_next_c,
  output logic          qbit_c
);

  logic [DW:0] t;
  logic [DW:0] diff;

  // r < divisor always holds, so t < 2*divisor and the new remainder fits in DW bits
  always_comb begin
    t        = {r, bit_in};
    diff     = t - {1'b0, divisor};
    qbit_c   = (t >= {1'b0, divisor});
    r_next_c = qbit_c ? diff[DW-1:0] : t[DW-1:0];
  end

endmodule

// File: rtl/div24u_seq.sv
// 2*DW / DW unsigned sequential restoring divider, one quotient bit per clock.
// Remainder output port is built only when DIV_REMAINDER_EN is defined.
module div24u_seq
  import div_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned LSB_IGNORE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  div24u_seq_if.slave  bus
);

  localparam int unsigned     CNT_W     = cnt_width(DW);
  localparam logic [2*DW-1:0] KEEP_MASK = {(2*DW){1'b1}} << LSB_IGNORE;

  state_e          state;
  state_e          state_n;

  logic [DW-1:0]   part_r;
  logic [DW-1:0]   divisor_q;
  logic [DW-1:0]   shift_q;
  logic [CNT_W-1:0] cnt;

  logic            in_ready_q;
  logic            out_valid_q;
  logic [DW-1:0]   quot_q;
  logic            ovf_q;
  logic            dz_q;

  logic [2*DW-1:0] dividend_eff_c;
  logic [DW-1:0]   hi_c;
  logic            accept_c;
  logic            dz_hit_c;
  logic            ovf_hit_c;
  logic            flagged_c;
  logic            last_step_c;
  logic [DW-1:0]   r_step_c;
  logic            qbit_c;

  div_step #(.DW(DW)) u_step (
    .r        (part_r),
    .bit_in   (shift_q[DW-1]),
    .divisor  (divisor_q),
    .r_next_c (r_step_c),
    .qbit_c   (qbit_c)
  );

  // Capture-time decode of the incoming operands
  always_comb begin
    dividend_eff_c = bus.dividend & KEEP_MASK;
    hi_c           = dividend_eff_c[2*DW-1:DW];
    accept_c       = bus.in_valid & in_ready_q;
    dz_hit_c       = (bus.divisor == '0);
    ovf_hit_c      = !dz_hit_c && (hi_c >= bus.divisor);
    flagged_c      = dz_q | ovf_q;
    last_step_c    = (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Flagged ops pass through CALC for one cycle so their result appears at E+1
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept_c) state_n = CALC;
      CALC:    if (flagged_c || last_step_c) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      part_r      <= '0;
      divisor_q   <= '0;
      shift_q     <= '0;
      cnt         <= '0;
    end else begin
      in_ready_q  <= (state_n == IDLE);
      out_valid_q <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (accept_c) begin
            divisor_q <= bus.divisor;
            shift_q   <= dividend_eff_c[DW-1:0];
            dz_q      <= dz_hit_c;
            ovf_q     <= ovf_hit_c;
            if (dz_hit_c || ovf_hit_c) begin
              quot_q <= '1;
              part_r <= '0;
              cnt    <= '0;
            end else begin
              quot_q <= '0;
              part_r <= hi_c;
              cnt    <= CNT_W'(DW);
            end
          end
        end
        CALC: begin
          if (!flagged_c) begin
            part_r  <= r_step_c;
            shift_q <= {shift_q[DW-2:0], 1'b0};
            quot_q  <= {quot_q[DW-2:0], qbit_c};
            cnt     <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_REMAINDER_EN
  logic [DW-1:0] rem_q;

  // Final remainder is latched on the last step; flagged ops report zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else if (state == IDLE && accept_c) begin
      rem_q <= '0;
    end else if (state == CALC && !flagged_c && last_step_c) begin
      rem_q <= r_step_c;
    end
  end

  assign bus.rem = rem_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quot      = quot_q;
  assign bus.ovf       = ovf_q;
  assign bus.dz        = dz_q;

endmodule
